ir_fetch: RTL

Multicycle instruction-fetch stage: on a start pulse from the control FSM, reads one 16-bit instruction as two bytes from byte-wide memory over a req/ack handshake. It loads the assembled word into the instruction register and splits it into fields. The `imm` field feeds the immediate zero-extender directly, and `opcode`/`rd`/`rs` go to control and the register file. The instruction register updates atomically: downstream never sees a half-loaded word.

---
 rtl/ir_fetch.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ir_fetch.sv
// ---------------------------------------------------------------------------
// ir_fetch
//
// Multicycle instruction-fetch stage. A one-cycle fetch_start pulse, when the
// block is idle, launches a read of one 16-bit big-endian instruction as two
// bytes from a byte-wide memory over a req/ack handshake. The high byte is
// parked in an internal buffer. The instruction register is only written
// when the low byte arrives, so downstream logic never sees a half-loaded
// word.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous reset, active-low
//   fetch_start  one-cycle fetch request, honoured only while idle
//   pc           instruction byte address, sampled when a fetch is accepted
//   mem_req      registered memory read request
//   mem_addr     registered byte address, stable while mem_req is high
//   mem_ack      memory presents valid mem_rdata this cycle
//   mem_rdata    read byte
//   ir           instruction register
//   opcode       ir[15:12]
//   rd           ir[11:8]
//   rs           ir[7:4]
//   imm          ir[7:0], feeds the immediate zero-extender
//   busy         high whenever a fetch is in progress
//   ir_valid     high once any fetch has completed since reset
//   done         one-cycle pulse in the cycle after ir is loaded
//   fetch_err    one-cycle pulse when a fetch is abandoned on timeout
//
// Build option:
//   IR_FETCH_TIMEOUT_EN  when defined, a 4-bit wait counter aborts a fetch
//                        after 15 consecutive cycles without mem_ack. When
//                        undefined the block waits forever for mem_ack and
//                        fetch_err is tied low.
// ---------------------------------------------------------------------------
module ir_fetch #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [7:0]        imm,
    output logic              busy,
    output logic              ir_valid,
    output logic              done,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2
    } state_t;

    // Increment used to step from the high-byte address to the low-byte
    // address; the add is ADDR_W bits wide so the top address wraps to 0.
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [7:0] hi_buf;
    logic       done_pend;

`ifdef IR_FETCH_TIMEOUT_EN
    // The counter holds the number of ack-less cycles seen so far for the
    // current request. When it already holds 14 and another cycle passes
    // without ack, it has reached 15 and the fetch is abandoned at that edge.
    localparam logic [3:0] WAIT_LAST = 4'd14;
    logic [3:0] wait_cnt;
`endif

    // Field decode is pure wiring from the instruction register, so the
    // fields change exactly when ir does and never in between.
    assign opcode = ir[15:12];
    assign rd     = ir[11:8];
    assign rs     = ir[7:4];
    assign imm    = ir[7:0];

    // Fetch sequencer. All outputs are registered here so that mem_req and
    // mem_addr never glitch. done is delayed one cycle behind the ir load
    // through done_pend, which places the pulse in the cycle after ir changes.
    // mem_addr doubles as the latched fetch address: it holds pc throughout
    // FETCH_HI, so pc + 1 for the low byte is derived from it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            hi_buf    <= 8'h00;
            ir        <= 16'h0000;
            busy      <= 1'b0;
            ir_valid  <= 1'b0;
            done_pend <= 1'b0;
            done      <= 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
            fetch_err <= 1'b0;
            wait_cnt  <= 4'd0;
`endif
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
            fetch_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // mem_ack is ignored here; a stray ack cannot disturb ir.
                    if (fetch_start) begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH_HI;
`ifdef IR_FETCH_TIMEOUT_EN
                        wait_cnt <= 4'd0;
`endif
                    end
                end

                FETCH_HI: begin
                    if (mem_ack) begin
                        // Big-endian: the byte at pc is the upper half.
                        hi_buf   <= mem_rdata;
                        mem_addr <= mem_addr + ADDR_ONE;
                        state    <= FETCH_LO;
`ifdef IR_FETCH_TIMEOUT_EN
                        wait_cnt <= 4'd0;
`endif
                    end else begin
`ifdef IR_FETCH_TIMEOUT_EN
                        if (wait_cnt == WAIT_LAST) begin
                            mem_req   <= 1'b0;
                            busy      <= 1'b0;
                            fetch_err <= 1'b1;
                            wait_cnt  <= 4'd0;
                            state     <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
`endif
                    end
                end

                FETCH_LO: begin
                    if (mem_ack) begin
                        // Both halves land in ir at one edge.
                        ir        <= {hi_buf, mem_rdata};
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        ir_valid  <= 1'b1;
                        done_pend <= 1'b1;
                        state     <= IDLE;
                    end else begin
`ifdef IR_FETCH_TIMEOUT_EN
                        // An abort leaves ir, ir_valid and done untouched.
                        if (wait_cnt == WAIT_LAST) begin
                            mem_req   <= 1'b0;
                            busy      <= 1'b0;
                            fetch_err <= 1'b1;
                            wait_cnt  <= 4'd0;
                            state     <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
`endif
                    end
                end

                default: begin
                    // Unused encoding: fall back to a clean idle.
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifndef IR_FETCH_TIMEOUT_EN
    // Without the timeout the block waits forever, so no error can occur.
    assign fetch_err = 1'b0;
`endif

endmodule
